sram_rw_arbiter: RTL and testbench
==================================

Name: sram_rw_arbiter

Overview:
- Shares the RW port (port 0) of the 32x512 OpenRAM macro between two requesters, A and B, using round-robin arbitration.
- Sequences the macro's timing: inputs are registered on posedge, and read data is driven after the following negedge.
- Returns read data to the requester that issued the read.
- Zero-fills the whole array after reset and on request. Port 1 (read-only) is outside this block.

Parameters:
ADDR_WIDTH, 9, macro word-address width
DATA_WIDTH, 32, word width
NUM_WMASKS, 4, byte-lane write-mask width (DATA_WIDTH/8)
INIT_CLEAR, 1, 1 = run the zero-fill sweep after reset; 0 = go straight to RUN

Ports:
clk  in  1  single clock, also drives macro clk0
rst_n  in  1  asynchronous active-low reset
a_req_valid  in  1  requester A command valid
a_req_ready  out  1  A command accepted when valid&ready at posedge
a_req_we  in  1  1=write, 0=read
a_req_addr  in  ADDR_WIDTH  word address
a_req_wmask  in  NUM_WMASKS  byte enables (writes only)
a_req_wdata  in  DATA_WIDTH  write data
a_rsp_valid  out  1  one-cycle pulse, read data for A
a_rsp_rdata  out  DATA_WIDTH  read data for A
b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wmask, b_req_wdata, b_rsp_valid, b_rsp_rdata: identical for B
clear_req  in  1  pulse: request a re-zero of the whole array
busy  out  1  high in INIT or DRAIN
sram_csb0  out  1  macro chip select, active low
sram_web0  out  1  macro write enable, active low
sram_wmask0  out  NUM_WMASKS  macro write mask
sram_addr0  out  ADDR_WIDTH  macro address
sram_din0  out  DATA_WIDTH  macro write data
sram_dout0  in  DATA_WIDTH  macro read data

Behaviour:

Reset values:
- FSM goes to INIT (or to RUN if INIT_CLEAR=0).
- Sweep counter = 0; rr_last = B, so A wins the first tie.
- Read pipeline valid bits = 0; clear_pending = 0.
- All rsp_valid = 0; rsp_rdata = 0.
- sram_csb0 = 1, sram_web0 = 1; every other sram output = 0.

Macro drive:
- Macro pins are combinational from the current grant or sweep. The macro samples them at the end of the cycle.
- Idle cycle: sram_csb0 = 1; web0, addr, din, wmask hold the last values or are don't-care.

FSM INIT:
- Each cycle: csb0=0, web0=0, wmask0=all ones, din0=0, addr0=counter. Counter increments.
- Leave for RUN after the cycle with counter = 2^ADDR_WIDTH-1.
- Both req_ready = 0 throughout.

FSM RUN, arbitration:
- One grant per cycle.
- Only one requester valid: it is granted.
- Both valid: grant goes to the requester that is not rr_last.
- rr_last updates on each accepted command.
- x_req_ready = (state==RUN) & ~clear_pending & (grant==x). Ready may depend on valid.
- Granted command drives the macro: csb0=0, web0=~we, addr, din, wmask.

FSM RUN, clear request:
- clear_req sets clear_pending; it is ignored while already in INIT/DRAIN.
- With clear_pending set, no commands are accepted and the FSM moves to DRAIN.

FSM DRAIN:
- Waits until the read pipeline is empty (at most 2 cycles).
- Then goes to INIT with counter=0 and clears clear_pending.

Read latency:
- Read accepted at posedge P0: the macro registers it at P0 and drives dout0 after the next negedge.
- Controller captures sram_dout0 into x_rsp_rdata at P1 and pulses x_rsp_valid for the cycle after P1.
- Pipeline: 1-stage tag register {valid, id}, set at P0 and consumed at P1.
- Throughput is 1 command per cycle. Reads back-to-back from A and B return in issue order.

Writes:
- No response. Lanes with wmask bit 0 are left unchanged. wmask=0 is a legal no-op write.

Read-after-write:
- Write accepted at P0, read of the same address accepted at P1: the read returns the new data, because the write lands on the negedge before the read's negedge. No stall.

rsp_rdata:
- Holds its value between pulses.
- No response backpressure: the requester must sink every pulse.

Reset mid-operation:
- In-flight reads are discarded with no rsp pulse. The sweep restarts from 0.

busy = (state != RUN).

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum {S_INIT, S_RUN, S_DRAIN};
  - requester-id type (1 bit, A=0, B=1);
  - SRAM_WORDS = 512;
  - the width constants.
- Sub-module sram_rr_arb2: 2-way round-robin grant plus rr_last register. Everything else stays in the top module.

Test Plan:
- Reset, INIT_CLEAR=1 -> exactly 512 write cycles (addr 0..511, din 0, wmask F), busy high for 512 cycles, then a_req_ready goes high.
- A writes 0xDEADBEEF to addr 5, then reads addr 5 the next cycle -> a_rsp_valid pulses in the cycle after the second posedge following the read accept, rdata = 0xDEADBEEF.
- A and B both valid every cycle, reads to addr 1 and 2 -> grants alternate A,B,A,B starting with A; each rsp is routed only to its issuer with the correct data.
- Write 0x11223344 full mask, then 0xAABBCCDD with wmask 4'b0101 to the same address -> read returns 0x11BB33DD.
- clear_req asserted while a read is in flight -> the read response is still delivered, ready drops, DRAIN then INIT sweep, and a later read returns 0.
- rst_n asserted at sweep counter 200 with a read in flight -> no rsp pulse; after release the sweep restarts at addr 0; sram_csb0=1 while rst_n is low.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the OpenRAM 32x512 RW-port controller.
package sram_ctrl_pkg;

   localparam int unsigned SRAM_ADDR_W     = 9;
   localparam int unsigned SRAM_DATA_W     = 32;
   localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_W / 8;
   localparam int unsigned SRAM_WORDS      = 512;

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_DRAIN
   } state_e;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter; rr_last remembers the most recent winner.
module sram_rr_arb2
   import sram_ctrl_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    en,
   input  logic    a_valid,
   input  logic    b_valid,
   output logic    grant_valid,
   output req_id_e grant_id
);

   req_id_e rr_last_q;

   always_comb begin
      grant_valid = en & (a_valid | b_valid);
      grant_id    = REQ_A;
      if (a_valid && b_valid) begin
         grant_id = (rr_last_q == REQ_B) ? REQ_A : REQ_B;
      end else if (b_valid) begin
         grant_id = REQ_B;
      end
   end

   // Reset to B so that A wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q <= REQ_B;
      end else if (grant_valid) begin
         rr_last_q <= grant_id;
      end
   end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares the RW port of a 32x512 OpenRAM macro between requesters A and B,
// returns read data to the issuer, and zero-fills the array after reset or on request.
module sram_rw_arbiter
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SRAM_ADDR_W,
   parameter int unsigned DATA_WIDTH = SRAM_DATA_W,
   parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
   parameter bit          INIT_CLEAR = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req_valid,
   output logic                  a_req_ready,
   input  logic                  a_req_we,
   input  logic [ADDR_WIDTH-1:0] a_req_addr,
   input  logic [NUM_WMASKS-1:0] a_req_wmask,
   input  logic [DATA_WIDTH-1:0] a_req_wdata,
   output logic                  a_rsp_valid,
   output logic [DATA_WIDTH-1:0] a_rsp_rdata,
   input  logic                  b_req_valid,
   output logic                  b_req_ready,
   input  logic                  b_req_we,
   input  logic [ADDR_WIDTH-1:0] b_req_addr,
   input  logic [NUM_WMASKS-1:0] b_req_wmask,
   input  logic [DATA_WIDTH-1:0] b_req_wdata,
   output logic                  b_rsp_valid,
   output logic [DATA_WIDTH-1:0] b_rsp_rdata,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam state_e                RESET_STATE = INIT_CLEAR ? S_INIT : S_RUN;
   localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST  = {ADDR_WIDTH{1'b1}};

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] sweep_cnt_q;
   logic                  clear_pending_q;
   logic                  tag_valid_q;
   req_id_e               tag_id_q;

   logic                  arb_en;
   logic                  sweep_active;
   logic                  grant_valid;
   req_id_e               grant_id;
   logic                  grant_we;
   logic [ADDR_WIDTH-1:0] grant_addr;
   logic [NUM_WMASKS-1:0] grant_wmask;
   logic [DATA_WIDTH-1:0] grant_wdata;

   // Gated by rst_n so the macro sees no access while reset is held.
   assign arb_en       = rst_n & (state_q == S_RUN) & ~clear_pending_q;
   assign sweep_active = rst_n & (state_q == S_INIT);
   assign busy         = (state_q != S_RUN);

   sram_rr_arb2 u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (arb_en),
      .a_valid     (a_req_valid),
      .b_valid     (b_req_valid),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign a_req_ready = grant_valid & (grant_id == REQ_A);
   assign b_req_ready = grant_valid & (grant_id == REQ_B);

   always_comb begin
      grant_we    = a_req_we;
      grant_addr  = a_req_addr;
      grant_wmask = a_req_wmask;
      grant_wdata = a_req_wdata;
      if (grant_id == REQ_B) begin
         grant_we    = b_req_we;
         grant_addr  = b_req_addr;
         grant_wmask = b_req_wmask;
         grant_wdata = b_req_wdata;
      end
   end

   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = '0;
      sram_din0   = '0;
      if (sweep_active) begin
         sram_csb0   = 1'b0;
         sram_web0   = 1'b0;
         sram_wmask0 = '1;
         sram_addr0  = sweep_cnt_q;
      end else if (grant_valid) begin
         sram_csb0   = 1'b0;
         sram_web0   = ~grant_we;
         sram_wmask0 = grant_wmask;
         sram_addr0  = grant_addr;
         sram_din0   = grant_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= RESET_STATE;
         sweep_cnt_q     <= '0;
         clear_pending_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_INIT: begin
               sweep_cnt_q <= sweep_cnt_q + 1'b1;
               if (sweep_cnt_q == SWEEP_LAST) begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (clear_pending_q) begin
                  state_q <= S_DRAIN;
               end else if (clear_req) begin
                  clear_pending_q <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (!tag_valid_q) begin
                  state_q         <= S_INIT;
                  sweep_cnt_q     <= '0;
                  clear_pending_q <= 1'b0;
               end
            end
            default: state_q <= RESET_STATE;
         endcase
      end
   end

   // Tag follows the read through the macro; dout0 is valid at the next posedge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid_q <= 1'b0;
         tag_id_q    <= REQ_A;
         a_rsp_valid <= 1'b0;
         b_rsp_valid <= 1'b0;
         a_rsp_rdata <= '0;
         b_rsp_rdata <= '0;
      end else begin
         tag_valid_q <= grant_valid & ~grant_we;
         tag_id_q    <= grant_id;
         a_rsp_valid <= tag_valid_q & (tag_id_q == REQ_A);
         b_rsp_valid <= tag_valid_q & (tag_id_q == REQ_B);
         if (tag_valid_q && (tag_id_q == REQ_A)) begin
            a_rsp_rdata <= sram_dout0;
         end
         if (tag_valid_q && (tag_id_q == REQ_B)) begin
            b_rsp_rdata <= sram_dout0;
         end
      end
   end

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Scoreboard bench for sram_rw_arbiter with a behavioural macro and a word-array reference.
module tb_sram_rw_arbiter;
   import sram_ctrl_pkg::*;

   typedef struct packed {
      logic        v;
      logic        we;
      logic [8:0]  addr;
      logic [3:0]  m;
      logic [31:0] d;
   } cmd_t;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req_valid = 1'b0, a_req_we = 1'b0, b_req_valid = 1'b0, b_req_we = 1'b0;
   logic [8:0]  a_req_addr = '0, b_req_addr = '0;
   logic [3:0]  a_req_wmask = '0, b_req_wmask = '0;
   logic [31:0] a_req_wdata = '0, b_req_wdata = '0;
   logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
   logic [31:0] a_rsp_rdata, b_rsp_rdata;
   logic        clear_req = 1'b0;
   logic        busy, sram_csb0, sram_web0;
   logic [3:0]  sram_wmask0;
   logic [8:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0 = '0;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] ref_mem [SRAM_WORDS];
   logic [31:0] mem [SRAM_WORDS];
   exp_t        qa [$];
   exp_t        qb [$];
   bit          rr_last = 1'b1;

   sram_rw_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_req_valid (a_req_valid),
      .a_req_ready (a_req_ready),
      .a_req_we    (a_req_we),
      .a_req_addr  (a_req_addr),
      .a_req_wmask (a_req_wmask),
      .a_req_wdata (a_req_wdata),
      .a_rsp_valid (a_rsp_valid),
      .a_rsp_rdata (a_rsp_rdata),
      .b_req_valid (b_req_valid),
      .b_req_ready (b_req_ready),
      .b_req_we    (b_req_we),
      .b_req_addr  (b_req_addr),
      .b_req_wmask (b_req_wmask),
      .b_req_wdata (b_req_wdata),
      .b_rsp_valid (b_rsp_valid),
      .b_rsp_rdata (b_rsp_rdata),
      .clear_req   (clear_req),
      .busy        (busy),
      .sram_csb0   (sram_csb0),
      .sram_web0   (sram_web0),
      .sram_wmask0 (sram_wmask0),
      .sram_addr0  (sram_addr0),
      .sram_din0   (sram_din0),
      .sram_dout0  (sram_dout0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Macro model: pins registered on posedge, write or read-out on the following negedge.
   logic        m_csb = 1'b1, m_web = 1'b1;
   logic [8:0]  m_addr = '0;
   logic [3:0]  m_wmask = '0;
   logic [31:0] m_din = '0;
   always @(posedge clk) begin
      m_csb   <= sram_csb0;
      m_web   <= sram_web0;
      m_addr  <= sram_addr0;
      m_wmask <= sram_wmask0;
      m_din   <= sram_din0;
   end
   always @(negedge clk) begin
      if (m_csb === 1'b0) begin
         if (m_web === 1'b0) begin
            for (int l = 0; l < 4; l++) if (m_wmask[l]) mem[m_addr][8*l +: 8] <= m_din[8*l +: 8];
         end else begin
            sram_dout0 <= mem[m_addr];
         end
      end
   end

   task automatic check(input bit ok, input string name, input string act, input string exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %s, expected %s", name, act, exp);
      end
   endtask

   // Monitor: every response pulse must match the head of its issuer's queue.
   always @(negedge clk) begin
      exp_t e;
      if (a_rsp_valid === 1'b1) begin
         check(qa.size() != 0, "a_rsp_expected", "pulse", "no pulse");
         if (qa.size() != 0) begin
            e = qa.pop_front();
            check(a_rsp_rdata === e.data && cyc == e.cyc, "a_rsp",
                  $sformatf("%h@%0d", a_rsp_rdata, cyc), $sformatf("%h@%0d", e.data, e.cyc));
         end
      end
      if (b_rsp_valid === 1'b1) begin
         check(qb.size() != 0, "b_rsp_expected", "pulse", "no pulse");
         if (qb.size() != 0) begin
            e = qb.pop_front();
            check(b_rsp_rdata === e.data && cyc == e.cyc, "b_rsp",
                  $sformatf("%h@%0d", b_rsp_rdata, cyc), $sformatf("%h@%0d", e.data, e.cyc));
         end
      end
   end

   function automatic cmd_t rd(input logic [8:0] addr);
      return '{v: 1'b1, we: 1'b0, addr: addr, m: 4'h0, d: 32'h0};
   endfunction
   function automatic cmd_t wr(input logic [8:0] addr, input logic [31:0] d, input logic [3:0] m);
      return '{v: 1'b1, we: 1'b1, addr: addr, m: m, d: d};
   endfunction
   function automatic cmd_t nop();
      return '{v: 1'b0, we: 1'b0, addr: 9'h0, m: 4'h0, d: 32'h0};
   endfunction

   task automatic model_reset();
      qa.delete();
      qb.delete();
      rr_last = 1'b1;
      for (int i = 0; i < SRAM_WORDS; i++) ref_mem[i] = '0;
   endtask

   task automatic accept(input bit id, input cmd_t c);
      exp_t e;
      if (c.we) begin
         for (int l = 0; l < 4; l++) if (c.m[l]) ref_mem[c.addr][8*l +: 8] = c.d[8*l +: 8];
      end else begin
         e.data = ref_mem[c.addr];
         e.cyc  = cyc + 2;
         if (id) qb.push_back(e);
         else qa.push_back(e);
      end
      rr_last = id;
   endtask

   // Called at posedge+1; returns at the next posedge+1 with the acceptance result.
   task automatic step(input cmd_t a, input cmd_t b, input logic clr, output logic ga,
                       output logic gb);
      a_req_valid = a.v; a_req_we = a.we; a_req_addr = a.addr; a_req_wmask = a.m;
      a_req_wdata = a.d;
      b_req_valid = b.v; b_req_we = b.we; b_req_addr = b.addr; b_req_wmask = b.m;
      b_req_wdata = b.d;
      clear_req = clr;
      @(negedge clk);
      ga = a.v & a_req_ready;
      gb = b.v & b_req_ready;
      if (ga) accept(1'b0, a);
      if (gb) accept(1'b1, b);
      if (clr) for (int i = 0; i < SRAM_WORDS; i++) ref_mem[i] = '0;
      @(posedge clk);
      #1;
      clear_req = 1'b0;
   endtask

   task automatic sweep_check(input int n, input string nm);
      int w = 0;
      int errs = 0;
      @(negedge clk);
      while (!(busy === 1'b1 && sram_csb0 === 1'b0) && w < 16) begin
         @(negedge clk);
         w++;
      end
      check(w < 16, {nm, "_start"}, $sformatf("wait=%0d", w), "wait<16");
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== i[8:0] ||
             sram_din0 !== 32'h0 || sram_wmask0 !== 4'hf || busy !== 1'b1 ||
             a_req_ready !== 1'b0) errs++;
      end
      check(errs == 0, nm, $sformatf("%0d bad cycles", errs), "0 bad cycles");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ga, gb, ea, eb;
      cmd_t ca, cb;
      for (int i = 0; i < SRAM_WORDS; i++) mem[i] = $urandom;
      model_reset();
      a_req_valid = 1'b1;
      repeat (2) @(negedge clk);
      check(sram_csb0 === 1'b1 && sram_web0 === 1'b1, "reset_csb_web",
            $sformatf("%b%b", sram_csb0, sram_web0), "11");
      check(sram_addr0 === 9'h0 && sram_din0 === 32'h0 && sram_wmask0 === 4'h0, "reset_pins",
            $sformatf("%h/%h/%h", sram_addr0, sram_din0, sram_wmask0), "0/0/0");
      check(a_rsp_valid === 1'b0 && b_rsp_valid === 1'b0 && a_rsp_rdata === 32'h0 &&
            b_rsp_rdata === 32'h0, "reset_rsp", $sformatf("%b%b %h %h", a_rsp_valid,
            b_rsp_valid, a_rsp_rdata, b_rsp_rdata), "00 0 0");
      check(busy === 1'b1 && a_req_ready === 1'b0, "reset_busy_ready",
            $sformatf("%b%b", busy, a_req_ready), "10");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sweep_check(512, "init_sweep");
      check(busy === 1'b0, "busy_after_sweep", $sformatf("%b", busy), "0");
      step(rd(9'd0), nop(), 1'b0, ga, gb);
      check(ga === 1'b1, "ready_after_sweep", $sformatf("%b", ga), "1");

      // Read-after-write, no stall.
      step(wr(9'd5, 32'hDEADBEEF, 4'hf), nop(), 1'b0, ga, gb);
      step(rd(9'd5), nop(), 1'b0, ga, gb);
      check(ga === 1'b1, "raw_read_accept", $sformatf("%b", ga), "1");

      // Ties alternate A,B,... after B was the last winner.
      step(wr(9'd1, 32'h11110001, 4'hf), nop(), 1'b0, ga, gb);
      step(nop(), wr(9'd2, 32'h22220002, 4'hf), 1'b0, ga, gb);
      for (int i = 0; i < 8; i++) begin
         step(rd(9'd1), rd(9'd2), 1'b0, ga, gb);
         check(ga === (i % 2 == 0) && gb === (i % 2 == 1), "tie_alternate",
               $sformatf("%b%b", ga, gb), (i % 2 == 0) ? "10" : "01");
      end

      // Byte-lane masks and a zero-mask no-op write.
      step(wr(9'd9, 32'h11223344, 4'hf), nop(), 1'b0, ga, gb);
      step(nop(), wr(9'd9, 32'hAABBCCDD, 4'b0101), 1'b0, ga, gb);
      step(rd(9'd9), nop(), 1'b0, ga, gb);
      step(nop(), wr(9'd9, 32'hFFFFFFFF, 4'h0), 1'b0, ga, gb);
      step(nop(), rd(9'd9), 1'b0, ga, gb);
      step(nop(), nop(), 1'b0, ga, gb);

      // Clear with a read in flight.
      step(rd(9'd5), nop(), 1'b1, ga, gb);
      check(ga === 1'b1, "clear_cycle_accept", $sformatf("%b", ga), "1");
      step(rd(9'd5), nop(), 1'b0, ga, gb);
      check(ga === 1'b0, "ready_drops", $sformatf("%b", ga), "0");
      sweep_check(512, "clear_sweep");
      step(rd(9'd5), nop(), 1'b0, ga, gb);
      check(ga === 1'b1, "ready_after_clear", $sformatf("%b", ga), "1");
      step(nop(), nop(), 1'b0, ga, gb);

      // Reset with a read in flight, then reset again part-way through the sweep.
      step(rd(9'd5), nop(), 1'b0, ga, gb);
      rst_n = 1'b0;
      model_reset();
      a_req_valid = 1'b1;
      ea = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (sram_csb0 !== 1'b1 || a_rsp_valid !== 1'b0) ea = 1'b0;
      end
      check(ea, "reset_quiet", $sformatf("csb=%b rsp=%b", sram_csb0, a_rsp_valid), "csb=1 rsp=0");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sweep_check(200, "sweep_partial");
      rst_n = 1'b0;
      @(negedge clk);
      check(sram_csb0 === 1'b1, "csb_in_reset", $sformatf("%b", sram_csb0), "1");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sweep_check(512, "sweep_restart");
      step(rd(9'd9), nop(), 1'b0, ga, gb);
      check(ga === 1'b1, "ready_after_restart", $sformatf("%b", ga), "1");

      // Random traffic over a small address window to exercise hazards and ties.
      for (int i = 0; i < 400; i++) begin
         ca = $urandom_range(0, 1) ? (($urandom_range(0, 1) != 0) ?
              wr(9'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15))) :
              rd(9'($urandom_range(0, 15)))) : nop();
         cb = $urandom_range(0, 1) ? (($urandom_range(0, 1) != 0) ?
              wr(9'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15))) :
              rd(9'($urandom_range(0, 15)))) : nop();
         if (ca.v && cb.v) begin
            ea = rr_last;
            eb = !rr_last;
         end else begin
            ea = ca.v;
            eb = cb.v;
         end
         step(ca, cb, 1'b0, ga, gb);
         if (ca.v || cb.v)
            check(ga === ea && gb === eb, "rand_grant", $sformatf("%b%b", ga, gb),
                  $sformatf("%b%b", ea, eb));
      end

      step(nop(), nop(), 1'b0, ga, gb);
      repeat (4) @(posedge clk);
      #1;
      check(qa.size() == 0 && qb.size() == 0, "all_rsp_delivered",
            $sformatf("%0d/%0d left", qa.size(), qb.size()), "0/0 left");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
